// File: rtl/cpu_pkg.sv
// Shared opcode map, ALU-op encodings, FSM state and control-bundle types
// for the multi-cycle CPU controller.
package cpu_pkg;

   localparam logic [3:0] OP_LW   = 4'b0000;
   localparam logic [3:0] OP_SW   = 4'b0001;
   localparam logic [3:0] OP_BEQ  = 4'b1011;
   localparam logic [3:0] OP_BNE  = 4'b1100;
   localparam logic [3:0] OP_JMP  = 4'b1101;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_ERROR
   } ctrl_state_t;

   typedef enum logic [2:0] {
      CL_LW,
      CL_SW,
      CL_RTYPE,
      CL_BRANCH,
      CL_JMP,
      CL_HALT,
      CL_ILLEGAL
   } instr_class_t;

   // Every control output the sequencer drives, bundled so it can be
   // defaulted and cleared as a unit.
   typedef struct packed {
      logic       ir_en;
      logic       pc_en;
      logic       jmp;
      logic       beq;
      logic       bne;
      logic       ram_read;
      logic       write_enable;
      logic       reg_write;
      logic       alu_src;
      logic       dest_reg;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       halted;
      logic       err;
   } ctrl_out_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode-to-instruction-class decoder.
module opcode_decode
   import cpu_pkg::*;
(
   input  logic [3:0]   op,
   output instr_class_t cls
);

   // Classify the 4-bit opcode; 1010 and 1110 fall through to illegal.
   always_comb begin
      cls = CL_ILLEGAL;
      case (op)
         OP_LW:   cls = CL_LW;
         OP_SW:   cls = CL_SW;
         4'b0010, 4'b0011, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1000, 4'b1001:
                  cls = CL_RTYPE;
         OP_BEQ,
         OP_BNE:  cls = CL_BRANCH;
         OP_JMP:  cls = CL_JMP;
         OP_HALT: cls = CL_HALT;
         default: cls = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes RAM with mem_ready and traps
// HALT, illegal opcodes and memory timeouts.
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned RETIRE_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          opcode,
   input  logic                mem_ready,
   output logic                ir_en,
   output logic                pc_en,
   output logic                jmp,
   output logic                beq,
   output logic                bne,
   output logic                ram_read,
   output logic                write_enable,
   output logic                reg_write,
   output logic                alu_src,
   output logic                dest_reg,
   output logic                mem_to_reg,
   output logic [1:0]          alu_op,
   output logic                halted,
   output logic                err,
   output logic [RETIRE_W-1:0] retired
);

   ctrl_state_t   state, next_state;
   logic [3:0]    op_q;
   logic [3:0]    dec_op;
   instr_class_t  cls;
   logic [7:0]    wait_cnt;
   ctrl_out_t     co;

   // One decoder serves both DECODE (live opcode, before op_q is loaded)
   // and the later states (latched op_q).
   assign dec_op = (state == S_DECODE) ? opcode : op_q;

   opcode_decode u_dec (
      .op  (dec_op),
      .cls (cls)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Capture the opcode while in DECODE.
   always_ff @(posedge clk) begin
      if (reset)                  op_q <= '0;
      else if (state == S_DECODE) op_q <= opcode;
   end

   // Count unanswered MEM cycles; cleared whenever MEM is not re-entered.
   always_ff @(posedge clk) begin
      if (reset)                                        wait_cnt <= '0;
      else if (state == S_MEM && next_state == S_MEM)   wait_cnt <= wait_cnt + 8'd1;
      else                                              wait_cnt <= '0;
   end

   // Retired-instruction counter, one per PC advance.
   always_ff @(posedge clk) begin
      if (reset)         retired <= '0;
      else if (co.pc_en) retired <= retired + RETIRE_W'(1);
   end

   // Next-state and control decode from state plus latched opcode.
   always_comb begin
      next_state = state;
      co         = '0;
      case (state)
         S_FETCH: begin
            co.ir_en   = 1'b1;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               CL_ILLEGAL: next_state = S_ERROR;
               CL_HALT:    next_state = S_HALT;
               default:    next_state = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               CL_BRANCH: begin
                  co.beq     = (op_q == OP_BEQ);
                  co.bne     = (op_q == OP_BNE);
                  co.alu_op  = ALU_SUB;
                  co.pc_en   = 1'b1;
                  next_state = S_FETCH;
               end
               CL_JMP: begin
                  co.jmp     = 1'b1;
                  co.pc_en   = 1'b1;
                  next_state = S_FETCH;
               end
               CL_LW, CL_SW: begin
                  co.alu_src = 1'b1;
                  co.alu_op  = ALU_ADD;
                  next_state = S_MEM;
               end
               CL_RTYPE: begin
                  co.alu_op  = ALU_FUNC;
                  next_state = S_WB;
               end
               default: next_state = S_ERROR;
            endcase
         end
         S_MEM: begin
            co.alu_src      = 1'b1;
            co.alu_op       = ALU_ADD;
            co.ram_read     = (cls == CL_LW);
            co.write_enable = (cls == CL_SW);
            // Ready is checked before the timeout so it wins on the last cycle.
            if (mem_ready) begin
               if (cls == CL_LW) begin
                  next_state = S_WB;
               end else begin
                  co.pc_en   = 1'b1;
                  next_state = S_FETCH;
               end
            end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
               next_state = S_ERROR;
            end
         end
         S_WB: begin
            co.reg_write = 1'b1;
            co.pc_en     = 1'b1;
            if (cls == CL_LW) begin
               co.mem_to_reg = 1'b1;
               co.alu_src    = 1'b1;
               co.alu_op     = ALU_ADD;
            end else begin
               co.dest_reg   = 1'b1;
               co.alu_op     = ALU_FUNC;
            end
            next_state = S_FETCH;
         end
         S_HALT:  co.halted = 1'b1;
         S_ERROR: co.err    = 1'b1;
         default: next_state = S_FETCH;
      endcase
      // Hold every output low while reset is asserted, even mid-access.
      if (reset) co = '0;
   end

   assign ir_en        = co.ir_en;
   assign pc_en        = co.pc_en;
   assign jmp          = co.jmp;
   assign beq          = co.beq;
   assign bne          = co.bne;
   assign ram_read     = co.ram_read;
   assign write_enable = co.write_enable;
   assign reg_write    = co.reg_write;
   assign alu_src      = co.alu_src;
   assign dest_reg     = co.dest_reg;
   assign mem_to_reg   = co.mem_to_reg;
   assign alu_op       = co.alu_op;
   assign halted       = co.halted;
   assign err          = co.err;

endmodule
